yz_monitor: RTL

YZ_MONITOR -- requirements
Module: yz_monitor

---
 rtl/yz_monitor.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/yz_monitor.sv
// yz_monitor: event counters and a pattern detector for the (y,z) outputs of an
// upstream decode stage, with a 4-phase snapshot read port.
//
// Ports:
//   clk     sole clock, rising edge
//   rst_n   synchronous active-low reset, highest priority
//   y, z    decode-stage outputs, captured on cycles with en=1
//   en      sample enable
//   clr     synchronous clear of counters, pattern FSM, ovf and pat_det
//   rd_req  snapshot request (4-phase handshake)
//   rd_ack  snapshot valid / acknowledge
//   rd_y    snapshot of the y event counter
//   rd_z    snapshot of the z event counter
//   rd_pat  snapshot of the pattern-hit counter
//   pat_det one-cycle pulse after a completed 11,01,00 sequence
//   ovf     sticky flag: some counter tried to count past all-ones
module yz_monitor #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned PAT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             y,
    input  logic             z,
    input  logic             en,
    input  logic             clr,
    input  logic             rd_req,
    output logic             rd_ack,
    output logic [CNT_W-1:0] rd_y,
    output logic [CNT_W-1:0] rd_z,
    output logic [PAT_W-1:0] rd_pat,
    output logic             pat_det,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GOT11 = 2'd1,
        GOT01 = 2'd2
    } state_t;

    state_t             state, state_n;
    logic               y_q, z_q, en_q;
    logic [CNT_W-1:0]   y_cnt, y_cnt_n;
    logic [CNT_W-1:0]   z_cnt, z_cnt_n;
    logic [PAT_W-1:0]   pat_cnt, pat_cnt_n;
    logic               ovf_n;
    logic               hit;
    logic               rd_ack_n;
    logic [CNT_W-1:0]   rd_y_n, rd_z_n;
    logic [PAT_W-1:0]   rd_pat_n;
    // Low while rd_req has been held high continuously since reset, so a
    // request that straddles reset is not honoured until it is re-issued.
    logic               rd_arm;
    logic [1:0]         smp;

    assign smp = {y_q, z_q};

    // Next-state: pattern FSM, saturating counters, clear, snapshot handshake
    always_comb begin
        state_n   = state;
        hit       = 1'b0;
        y_cnt_n   = y_cnt;
        z_cnt_n   = z_cnt;
        pat_cnt_n = pat_cnt;
        ovf_n     = ovf;
        rd_ack_n  = rd_ack;
        rd_y_n    = rd_y;
        rd_z_n    = rd_z;
        rd_pat_n  = rd_pat;

        // Disabled cycles leave the FSM and counters untouched
        if (en_q) begin
            case (state)
                IDLE:    if (smp == 2'b11) state_n = GOT11;
                GOT11: begin
                    if (smp == 2'b11)      state_n = GOT11;
                    else if (smp == 2'b01) state_n = GOT01;
                    else                   state_n = IDLE;
                end
                GOT01: begin
                    if (smp == 2'b00) begin
                        state_n = IDLE;
                        hit     = 1'b1;
                    end else if (smp == 2'b11) begin
                        state_n = GOT11;
                    end else begin
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase

            if (y_q) begin
                if (y_cnt == '1) ovf_n = 1'b1;
                else             y_cnt_n = y_cnt + CNT_W'(1);
            end
            if (z_q) begin
                if (z_cnt == '1) ovf_n = 1'b1;
                else             z_cnt_n = z_cnt + CNT_W'(1);
            end
        end

        if (hit) begin
            if (pat_cnt == '1) ovf_n = 1'b1;
            else               pat_cnt_n = pat_cnt + PAT_W'(1);
        end

        // Clear wins over any count or hit on the same edge
        if (clr) begin
            state_n   = IDLE;
            hit       = 1'b0;
            y_cnt_n   = '0;
            z_cnt_n   = '0;
            pat_cnt_n = '0;
            ovf_n     = 1'b0;
        end

        // Snapshot captures the values this same edge writes into the counters
        if (rd_req && !rd_ack && rd_arm) begin
            rd_ack_n = 1'b1;
            rd_y_n   = y_cnt_n;
            rd_z_n   = z_cnt_n;
            rd_pat_n = pat_cnt_n;
        end else if (!rd_req) begin
            rd_ack_n = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            y_q     <= 1'b0;
            z_q     <= 1'b0;
            en_q    <= 1'b0;
            y_cnt   <= '0;
            z_cnt   <= '0;
            pat_cnt <= '0;
            ovf     <= 1'b0;
            pat_det <= 1'b0;
            rd_ack  <= 1'b0;
            rd_y    <= '0;
            rd_z    <= '0;
            rd_pat  <= '0;
            rd_arm  <= ~rd_req;
        end else begin
            state   <= state_n;
            en_q    <= en;
            if (en) begin
                y_q <= y;
                z_q <= z;
            end
            y_cnt   <= y_cnt_n;
            z_cnt   <= z_cnt_n;
            pat_cnt <= pat_cnt_n;
            ovf     <= ovf_n;
            pat_det <= hit;
            rd_ack  <= rd_ack_n;
            rd_y    <= rd_y_n;
            rd_z    <= rd_z_n;
            rd_pat  <= rd_pat_n;
            if (!rd_req) rd_arm <= 1'b1;
        end
    end

endmodule
